reg_file_sb: RTL and testbench

Parametrised successor to the team's 16x16 register file. It keeps two combinational read ports, a primary write port and a dedicated write/read port for one special register (the 16-bit register 14 case). It adds configurable width and depth, optional write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard. The pipeline decode stage uses the scoreboard to detect RAW hazards. The block sits between decode (reads, issue) and writeback.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_scoreboard.sv | 67 ++++++
 rtl/reg_file_sb.sv | 103 ++++++++++
 tb/tb_reg_file_sb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file with scoreboard.
package reg_file_pkg;

  localparam int DEF_DW       = 16;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_SPEC_IDX = 14;

  // Ceiling log2, used to derive the address width from the register count.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on issue, cleared on
// writeback, plus a registered population count and busy lookups for decode.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int   DEPTH    = DEF_DEPTH,
  parameter int   SPEC_IDX = DEF_SPEC_IDX,
  parameter bit   ZERO_REG = 1'b0,
  localparam int  AW       = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  input  logic          reg_we,
  input  logic [AW-1:0] w_addr,
  input  logic          spec_we,
  input  logic [AW-1:0] op1_addr,
  input  logic [AW-1:0] op2_addr,
  output logic          op1_busy,
  output logic          op2_busy,
  output logic [AW:0]   pend_cnt
);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;

  // Next pending vector: a new issue supersedes a same-cycle writeback.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pend_d = pend_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (iss_valid && iss_addr == AW'(r)) begin
        pend_d[r] = 1'b1;
      end else if ((reg_we && w_addr == AW'(r)) || (spec_we && r == SPEC_IDX)) begin
        pend_d[r] = 1'b0;
      end
    end
    if (ZERO_REG) pend_d[0] = 1'b0;
  end

  // Population count of the next vector, so the registered count tracks pend_q.
  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, pend_d[r]};
    end
  end

  // Pending bits and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Busy reflects the stored bit only; a same-cycle writeback still stalls decode once more.
  assign op1_busy = pend_q[op1_addr];
  assign op2_busy = pend_q[op2_addr];
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file: two combinational read ports with optional
// write bypass, a primary write port, a dedicated special-register port,
// optional hardwired-zero register 0 and a pending-bit scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int  DW       = DEF_DW,
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  SPEC_IDX = DEF_SPEC_IDX,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  ZERO_REG = 1'b0,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] op1_addr,
  input  logic [AW-1:0] op2_addr,
  output logic [DW-1:0] op1_data,
  output logic [DW-1:0] op2_data,
  output logic          op1_busy,
  output logic          op2_busy,
  input  logic          reg_we,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  input  logic          spec_we,
  input  logic [DW-1:0] w_spec,
  output logic [DW-1:0] spec_data,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  output logic [AW:0]   pend_cnt
);

  localparam logic [AW-1:0] SPEC_A = AW'(SPEC_IDX);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] rd_data [2];
  logic          wr_ok, spec_ok;

  // Writes to a hardwired-zero register 0 are dropped.
  assign wr_ok   = reg_we  && !(ZERO_REG && w_addr == '0);
  assign spec_ok = spec_we && !(ZERO_REG && SPEC_IDX == 0);

  // Next storage contents; the primary port is applied last so it wins a collision.
  always_comb begin
    mem_d = mem_q;
    if (spec_ok) mem_d[SPEC_IDX] = w_spec;
    if (wr_ok)   mem_d[w_addr]   = w_data;
  end

  // Storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the array is reset explicitly because every register must read 0 after reset; this rules out plain RAM macros.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_addr[0] = op1_addr;
  assign rd_addr[1] = op2_addr;

  // Read muxes: stored value, overridden by same-cycle writes when bypass is on.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_addr[p]];
      if (BYPASS) begin
        if (reg_we && w_addr == rd_addr[p]) begin
          rd_data[p] = w_data;
        end else if (spec_we && rd_addr[p] == SPEC_A) begin
          rd_data[p] = w_spec;
        end
      end
      if (ZERO_REG && rd_addr[p] == '0) rd_data[p] = '0;
    end
  end

  assign op1_data  = rd_data[0];
  assign op2_data  = rd_data[1];
  assign spec_data = mem_q[SPEC_IDX];

  reg_file_scoreboard #(
    .DEPTH    (DEPTH),
    .SPEC_IDX (SPEC_IDX),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .reg_we    (reg_we),
    .w_addr    (w_addr),
    .spec_we   (spec_we),
    .op1_addr  (op1_addr),
    .op2_addr  (op2_addr),
    .op1_busy  (op1_busy),
    .op2_busy  (op2_busy),
    .pend_cnt  (pend_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench: two builds (16x16 bypass, and 32x32 no-bypass with zero register
// and special index 5) driven by shared stimulus; expectations from a
// behavioural model are queued and compared by an independent monitor.
module tb_reg_file_sb;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus (widest build); the 16-entry build sees the low bits.
  logic        rst;
  logic        reg_we, spec_we, iss_valid;
  logic [4:0]  w_addr, iss_addr, op1_addr, op2_addr;
  logic [31:0] w_data, w_spec;

  logic [15:0] a_op1_data, a_op2_data, a_spec_data;
  logic        a_op1_busy, a_op2_busy;
  logic [4:0]  a_pend_cnt;
  logic [31:0] b_op1_data, b_op2_data, b_spec_data;
  logic        b_op1_busy, b_op2_busy;
  logic [5:0]  b_pend_cnt;

  reg_file_sb dut_a (
    .clk(clk), .rst(rst),
    .op1_addr(op1_addr[3:0]), .op2_addr(op2_addr[3:0]),
    .op1_data(a_op1_data), .op2_data(a_op2_data),
    .op1_busy(a_op1_busy), .op2_busy(a_op2_busy),
    .reg_we(reg_we), .w_addr(w_addr[3:0]), .w_data(w_data[15:0]),
    .spec_we(spec_we), .w_spec(w_spec[15:0]), .spec_data(a_spec_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr[3:0]), .pend_cnt(a_pend_cnt)
  );

  reg_file_sb #(.DW(32), .DEPTH(32), .SPEC_IDX(5), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .op1_addr(op1_addr), .op2_addr(op2_addr),
    .op1_data(b_op1_data), .op2_data(b_op2_data),
    .op1_busy(b_op1_busy), .op2_busy(b_op2_busy),
    .reg_we(reg_we), .w_addr(w_addr), .w_data(w_data),
    .spec_we(spec_we), .w_spec(w_spec), .spec_data(b_spec_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .pend_cnt(b_pend_cnt)
  );

  // Per-build configuration of the reference model.
  int          depth_m [2] = '{16, 32};
  int          spec_m  [2] = '{14, 5};
  bit          byp_m   [2] = '{1'b1, 1'b0};
  bit          zero_m  [2] = '{1'b0, 1'b1};
  logic [31:0] mask_m  [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};

  // Reference state: register contents and set of pending registers.
  logic [31:0] regs_m [2][32];
  logic [31:0] pend_m [2];

  typedef struct {
    int          dut;
    logic [31:0] op1_data, op2_data, spec_data, pend_cnt;
    logic        op1_busy, op2_busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input int k, input logic [4:0] addr);
    int ad, wa;
    ad = int'(addr) % depth_m[k];
    wa = int'(w_addr) % depth_m[k];
    if (zero_m[k] && ad == 0) return 32'h0;
    if (byp_m[k] && reg_we && wa == ad) return w_data & mask_m[k];
    if (byp_m[k] && spec_we && ad == spec_m[k]) return w_spec & mask_m[k];
    return regs_m[k][ad];
  endfunction

  function automatic exp_t expect_for(input int k);
    exp_t e;
    e.dut       = k;
    e.op1_data  = exp_read(k, op1_addr);
    e.op2_data  = exp_read(k, op2_addr);
    e.op1_busy  = pend_m[k][int'(op1_addr) % depth_m[k]];
    e.op2_busy  = pend_m[k][int'(op2_addr) % depth_m[k]];
    e.spec_data = regs_m[k][spec_m[k]];
    e.pend_cnt  = 32'($countones(pend_m[k]));
    return e;
  endfunction

  // Model update at a clock edge from the inputs presented during the cycle.
  task automatic commit(input int k);
    int wa, ia;
    wa = int'(w_addr) % depth_m[k];
    ia = int'(iss_addr) % depth_m[k];
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_m[k][i] = 32'h0;
      pend_m[k] = 32'h0;
    end else begin
      if (spec_we) regs_m[k][spec_m[k]] = w_spec & mask_m[k];
      if (reg_we)  regs_m[k][wa] = w_data & mask_m[k];
      if (reg_we)  pend_m[k][wa] = 1'b0;
      if (spec_we) pend_m[k][spec_m[k]] = 1'b0;
      if (iss_valid) pend_m[k][ia] = 1'b1;
      if (zero_m[k]) begin
        regs_m[k][0] = 32'h0;
        pend_m[k][0] = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic swe, input logic [31:0] ws, input logic iv, input logic [4:0] ia,
                       input logic [4:0] a1, input logic [4:0] a2);
    rst = r; reg_we = we; w_addr = wa; w_data = wd;
    spec_we = swe; w_spec = ws; iss_valid = iv; iss_addr = ia;
    op1_addr = a1; op2_addr = a2;
    if (!r) begin
      sb_q.push_back(expect_for(0));
      sb_q.push_back(expect_for(1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    commit(0);
    commit(1);
    #1;
    rst = 1'b0; reg_we = 1'b0; spec_we = 1'b0; iss_valid = 1'b0;
  endtask

  // Monitor: every cycle the DUTs present outputs; compare against queued expectations.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.dut == 0) begin
        check("a_op1_data", 32'(a_op1_data), e.op1_data);
        check("a_op2_data", 32'(a_op2_data), e.op2_data);
        check("a_op1_busy", 32'(a_op1_busy), 32'(e.op1_busy));
        check("a_op2_busy", 32'(a_op2_busy), 32'(e.op2_busy));
        check("a_spec_data", 32'(a_spec_data), e.spec_data);
        check("a_pend_cnt", 32'(a_pend_cnt), e.pend_cnt);
      end else begin
        check("b_op1_data", b_op1_data, e.op1_data);
        check("b_op2_data", b_op2_data, e.op2_data);
        check("b_op1_busy", 32'(b_op1_busy), 32'(e.op1_busy));
        check("b_op2_busy", 32'(b_op2_busy), 32'(e.op2_busy));
        check("b_spec_data", b_spec_data, e.spec_data);
        check("b_pend_cnt", 32'(b_pend_cnt), e.pend_cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) regs_m[k][i] = 32'h0;
      pend_m[k] = 32'h0;
    end
    rst = 1'b1; reg_we = 1'b0; spec_we = 1'b0; iss_valid = 1'b0;
    w_addr = '0; w_data = '0; w_spec = '0; iss_addr = '0; op1_addr = '0; op2_addr = '0;
    @(posedge clk); #1;

    // Reset with junk writes and issues pending alongside it.
    drive(1, 1, 5'd3, 32'h1111_2222, 1, 32'h3333_4444, 1, 5'd7, 5'd3, 5'd7);
    step();

    // Read address pairs after reset.
    for (int i = 1; i < 16; i += 2) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 5'(i), (i == 15) ? 5'd14 : 5'(i + 1));
      step();
    end
    check("t1_a_pend_cnt", 32'(a_pend_cnt), 32'd0);

    // Primary and special writes together; bypass visible during the write on build A.
    drive(0, 1, 5'd1, 32'h0000_3142, 1, 32'h0000_5678, 0, 0, 5'd1, 5'd15);
    #1;
    check("t2_a_bypass", 32'(a_op1_data), 32'h3142);
    step();
    op1_addr = 5'd1; op2_addr = 5'd15; #1;
    check("t2_a_op1", 32'(a_op1_data), 32'h3142);
    check("t2_a_spec", 32'(a_spec_data), 32'h5678);
    check("t2_b_op1", b_op1_data, 32'h3142);
    check("t2_b_spec", b_spec_data, 32'h5678);

    // Collision on the special register: primary port wins.
    drive(0, 1, 5'd14, 32'h0000_BEEF, 1, 32'h0000_DEAD, 0, 0, 5'd14, 5'd15);
    step();
    op1_addr = 5'd14; #1;
    check("t3_a_reg14", 32'(a_op1_data), 32'hBEEF);
    check("t3_a_spec", 32'(a_spec_data), 32'hBEEF);
    check("t3_b_reg14", b_op1_data, 32'hBEEF);
    check("t3_b_spec", b_spec_data, 32'hDEAD);

    // Scoreboard set / clear / issue-over-writeback.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd10);  step();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd10, 5'd8, 5'd10); step();
    op1_addr = 5'd8; #1;
    check("t4_a_cnt2", 32'(a_pend_cnt), 32'd2);
    check("t4_a_busy8", 32'(a_op1_busy), 32'd1);
    drive(0, 1, 5'd8, 32'h0000_0808, 0, 0, 0, 0, 5'd8, 5'd10);
    #1;
    check("t4_a_busy_wb_cycle", 32'(a_op1_busy), 32'd1);
    step();
    op1_addr = 5'd8; #1;
    check("t4_a_busy_clr", 32'(a_op1_busy), 32'd0);
    check("t4_a_cnt1", 32'(a_pend_cnt), 32'd1);
    drive(0, 1, 5'd8, 32'h0000_0888, 0, 0, 1, 5'd8, 5'd8, 5'd10);
    step();
    op1_addr = 5'd8; #1;
    check("t4_a_busy_kept", 32'(a_op1_busy), 32'd1);
    check("t4_a_cnt2b", 32'(a_pend_cnt), 32'd2);

    // Writes and issues to address 0 (ignored on the zero-register build).
    drive(0, 1, 5'd0, 32'h0000_FFFF, 0, 0, 1, 5'd0, 5'd0, 5'd8);
    #1;
    check("t5_b_zero_bypass", b_op1_data, 32'h0);
    step();
    op1_addr = 5'd0; #1;
    check("t5_b_zero_data", b_op1_data, 32'h0);
    check("t5_b_zero_busy", 32'(b_op1_busy), 32'd0);
    check("t5_b_cnt", 32'(b_pend_cnt), 32'd2);
    check("t5_a_reg0", 32'(a_op1_data), 32'hFFFF);
    check("t5_a_busy0", 32'(a_op1_busy), 32'd1);
    check("t5_a_cnt", 32'(a_pend_cnt), 32'd3);

    // Reset in the middle of traffic overrides the write and issue.
    drive(1, 1, 5'd3, 32'h0000_AAAA, 1, 32'h0000_5555, 1, 5'd4, 5'd3, 5'd4);
    step();
    op1_addr = 5'd3; op2_addr = 5'd4; #1;
    check("t6_a_cnt", 32'(a_pend_cnt), 32'd0);
    check("t6_b_cnt", 32'(b_pend_cnt), 32'd0);
    check("t6_a_data", 32'(a_op1_data), 32'h0);
    check("t6_a_busy", 32'(a_op2_busy), 32'd0);
    check("t6_a_spec", 32'(a_spec_data), 32'h0);
    drive(0, 1, 5'd1, 32'hCAFE_F00D, 1, 32'h1234_5678, 0, 0, 5'd1, 5'd5);
    step();
    op1_addr = 5'd1; #1;
    check("t6_b_op1", b_op1_data, 32'hCAFE_F00D);
    check("t6_b_spec", b_spec_data, 32'h1234_5678);
    check("t6_a_op1", 32'(a_op1_data), 32'hF00D);

    // Randomised traffic with occasional resets.
    repeat (400) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom), 5'($urandom), $urandom,
            ($urandom_range(0, 3) == 0), $urandom, 1'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom));
      step();
    end

    @(negedge clk); #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
